ce_window_feeder: RTL and testbench

- Transmit side of the CE data interface: turns a raster pixel stream (one pixel, all CL_IN channels, per cycle) into flattened KERNEL x KERNEL x CL_IN windows on data2conv with en_out, which drives CE en_in.
- Holds KERNEL-1 line buffers plus a KERNEL x KERNEL window shift register per channel.
- Emits only "valid" (unpadded) convolution windows, one per accepted pixel once the window is complete.

---
 rtl/ce_window_feeder_pkg.sv | 27 ++
 rtl/ce_window_feeder_line_buf.sv | 43 ++++
 rtl/ce_window_feeder.sv | 172 +++++++++++++++++
 tb/tb_ce_window_feeder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ce_window_feeder_pkg.sv
// Shared CE constants and helpers: window sizing, flattened (c,r,k) indexing, counter widths.
// Latency: none (package only).
// Backpressure: none (package only).
package ce_window_feeder_pkg;

    // Sign-extension bits added to one N-bit operand before the CE multiply.
    localparam int E1 = 1;
    // Guard bits added on top of the product width for the CE accumulator.
    localparam int E2 = 4;

    // Number of N-bit elements in one flattened window.
    function automatic int win_elems(input int cl_in, input int kernel);
        return cl_in * kernel * kernel;
    endfunction

    // Element position of channel c, window row r (0 = oldest/top),
    // window column k (0 = oldest/left). CE weights use the same order.
    function automatic int flat_idx(input int c, input int r, input int k, input int kernel);
        return c * kernel * kernel + r * kernel + k;
    endfunction

    // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ce_window_feeder_line_buf.sv
// Enable-gated delay line of DEPTH words: dout is the word written DEPTH enables earlier.
// Latency: DEPTH enabled cycles; dout is combinational from the RAM at the current pointer.
// Backpressure: none; en simply freezes pointer and contents.
module ce_line_buf
    import ce_window_feeder_pkg::*;
#(
    parameter int DEPTH = 28,
    parameter int WIDTH = 56
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int             AW   = cnt_w(DEPTH);
    localparam logic [AW-1:0]  LAST = AW'(DEPTH - 1);

    // RAM contents are deliberately not reset; the window gating upstream
    // never lets words older than the current frame reach the output.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    // Single pointer: read-before-write at the same slot yields a DEPTH-word delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
        end
    end

    // Write the incoming word into the slot just read out.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    assign dout = mem[ptr];

endmodule

// File: rtl/ce_window_feeder.sv
// Raster pixel stream -> flattened KERNEL x KERNEL x CL_IN valid-only windows for the CE (WIN_STRIDE2_EN: stride-2 emission).
// Latency: one cycle from the completing pixel to en_out/data2conv.
// Backpressure: none; pix_valid low freezes all state and gives en_out=0 the next cycle.
module ce_window_feeder
    import ce_window_feeder_pkg::*;
#(
    parameter int CL_IN  = 14,
    parameter int KERNEL = 7,
    parameter int N      = 4,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CL_IN*N-1:0]                 pix_in,
    input  logic                               pix_valid,
    input  logic                               sof,
    output logic [CL_IN*KERNEL*KERNEL*N-1:0]   data2conv,
    output logic                               en_out,
    output logic                               frame_done
);

    localparam int PW  = CL_IN * N;
    localparam int NE  = win_elems(CL_IN, KERNEL);
    localparam int NLB = (KERNEL > 1) ? KERNEL - 1 : 1;
    localparam int CW  = cnt_w(IMG_W);
    localparam int RW  = cnt_w(IMG_H);

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KERNEL - 1);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KERNEL - 1);

`ifdef WIN_STRIDE2_EN
    // Last window position reachable in steps of two from the first one.
    localparam logic [CW-1:0] COL_LAST_WIN = CW'(KERNEL - 1 + 2 * ((IMG_W - KERNEL) / 2));
    localparam logic [RW-1:0] ROW_LAST_WIN = RW'(KERNEL - 1 + 2 * ((IMG_H - KERNEL) / 2));
`else
    localparam logic [CW-1:0] COL_LAST_WIN = COL_LAST;
    localparam logic [RW-1:0] ROW_LAST_WIN = ROW_LAST;
`endif

    logic [CW-1:0]   col_cnt;
    logic [RW-1:0]   row_cnt;
    logic [CW-1:0]   cur_col;
    logic [RW-1:0]   cur_row;
    logic [CW-1:0]   col_nxt;
    logic [RW-1:0]   row_nxt;
    logic            emit;
    logic            emit_last;
    logic [NE*N-1:0] win_q;

    logic [PW-1:0]   lb_din  [NLB];
    logic [PW-1:0]   lb_dout [NLB];
    logic [N-1:0]    col_in  [KERNEL][CL_IN];

    // ------------------------------------------------------------------
    // Line-buffer cascade: buffer j holds the row j+1 above the input row.
    // ------------------------------------------------------------------
    generate
        if (KERNEL > 1) begin : g_lb
            for (genvar j = 0; j < NLB; j++) begin : g_buf
                if (j == 0) begin : g_first
                    assign lb_din[j] = pix_in;
                end else begin : g_next
                    assign lb_din[j] = lb_dout[j-1];
                end
                ce_line_buf #(
                    .DEPTH (IMG_W),
                    .WIDTH (PW)
                ) u_line_buf (
                    .clk  (clk),
                    .rst  (rst),
                    .en   (pix_valid),
                    .din  (lb_din[j]),
                    .dout (lb_dout[j])
                );
            end
        end else begin : g_no_lb
            // A 1x1 window needs no history; the placeholders stay inert.
            assign lb_din[0]  = pix_in;
            assign lb_dout[0] = '0;
        end
    endgenerate

    // Position of the pixel on the input this cycle; sof forces it to the frame origin.
    always_comb begin
        cur_col = sof ? '0 : col_cnt;
        cur_row = sof ? '0 : row_cnt;
    end

    // Raster advance from the current pixel, wrapping at the image edges.
    always_comb begin
        col_nxt = cur_col + CW'(1);
        row_nxt = cur_row;
        if (cur_col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end
    end

    // A window is complete once the pixel sits at least KERNEL-1 rows and
    // columns into the frame; rows above were all written this frame.
    always_comb begin
        emit = pix_valid && (cur_row >= ROW_FIRST_WIN) && (cur_col >= COL_FIRST_WIN);
`ifdef WIN_STRIDE2_EN
        // Offsets from the first window must both be even.
        emit = emit && (cur_row[0] == ROW_FIRST_WIN[0]) && (cur_col[0] == COL_FIRST_WIN[0]);
`endif
        emit_last = emit && (cur_row == ROW_LAST_WIN) && (cur_col == COL_LAST_WIN);
    end

    // Raster counters move only on accepted pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (pix_valid) begin
            col_cnt <= col_nxt;
            row_cnt <= row_nxt;
        end
    end

    // Output strobes, registered alongside the window they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_out     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            en_out     <= emit;
            frame_done <= emit_last;
        end
    end

    // New right-hand column: bottom row is the live pixel, rows above come
    // from progressively older line buffers.
    always_comb begin
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < CL_IN; c++) begin
                col_in[r][c] = '0;
                if (r == KERNEL - 1) begin
                    col_in[r][c] = pix_in[c*N +: N];
                end else begin
                    col_in[r][c] = lb_dout[(KERNEL >= 2 + r) ? KERNEL - 2 - r : 0][c*N +: N];
                end
            end
        end
    end

    // Window shift register: every row slides left, the new column lands at k=KERNEL-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
        end else if (pix_valid) begin
            for (int c = 0; c < CL_IN; c++) begin
                for (int r = 0; r < KERNEL; r++) begin
                    for (int k = 0; k < KERNEL; k++) begin
                        if (k < KERNEL - 1) begin
                            win_q[flat_idx(c, r, k, KERNEL)*N +: N] <= win_q[flat_idx(c, r, k + 1, KERNEL)*N +: N];
                        end else begin
                            win_q[flat_idx(c, r, k, KERNEL)*N +: N] <= col_in[r][c];
                        end
                    end
                end
            end
        end
    end

    // The window register is already in CE order; it is presented directly.
    assign data2conv = win_q;

endmodule

// File: tb/tb_ce_window_feeder.sv
// Self-checking bench for ce_window_feeder on a 5x4 single-channel image with a 3x3 kernel.
// Latency expectation: one cycle from completing pixel to en_out.
// Backpressure: none; idle cycles are inserted by the stimulus.
module tb_ce_window_feeder;

    localparam int CL_IN = 1;
    localparam int K     = 3;
    localparam int N     = 4;
    localparam int W     = 5;
    localparam int H     = 4;
    localparam int DW    = CL_IN * K * K * N;

`ifdef WIN_STRIDE2_EN
    localparam bit STRIDE2  = 1'b1;
    localparam int EXP_WINS = 2;
    localparam int EXP_LAST = 14;
`else
    localparam bit STRIDE2  = 1'b0;
    localparam int EXP_WINS = 6;
    localparam int EXP_LAST = 19;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   pix_in = '0;
    logic           pix_valid = 1'b0;
    logic           sof = 1'b0;
    logic [DW-1:0]  data2conv;
    logic           en_out;
    logic           frame_done;

    ce_window_feeder #(
        .CL_IN  (CL_IN),
        .KERNEL (K),
        .N      (N),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .data2conv  (data2conv),
        .en_out     (en_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // model state: current raster position and the image seen so far this frame
    int            mr = 0;
    int            mc = 0;
    logic [N-1:0]  img [H][W];

    // expectations for the outputs visible after the latest rising edge
    bit            exp_en  = 1'b0;
    bit            exp_fd  = 1'b0;
    logic [DW-1:0] exp_dat = '0;
    int            exp_idx = 0;

    // per-test observations
    int            win_cnt   = 0;
    int            fd_cnt    = 0;
    int            first_idx = -1;
    int            fd_idx    = -1;
    logic [DW-1:0] first_win = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic bit eligible(input int r, input int c);
        if (r < K - 1 || c < K - 1) return 1'b0;
        if (STRIDE2 && ((((r - (K - 1)) % 2) != 0) || (((c - (K - 1)) % 2) != 0))) return 1'b0;
        return 1'b1;
    endfunction

    // last window of the frame = no eligible position follows it in raster order
    function automatic bit is_last(input int r, input int c);
        for (int p = r * W + c + 1; p < W * H; p++) begin
            if (eligible(p / W, p % W)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // test-plan pixel value for raster index p
    function automatic logic [N-1:0] pv(input int p);
        return 4'((((p / W) * 5) + (p % W)) % 16);
    endfunction

    function automatic logic [DW-1:0] plan_win();
        logic [DW-1:0] w;
        int vals [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        w = '0;
        for (int i = 0; i < 9; i++) w[i*N +: N] = 4'(vals[i]);
        return w;
    endfunction

    // drive one cycle and advance the model by the same input
    task automatic step(input logic v, input logic s, input logic [N-1:0] p);
        bit            e;
        bit            f;
        logic [DW-1:0] d;
        int            idx;
        e = 1'b0; f = 1'b0; d = '0; idx = -1;
        if (v) begin
            if (s) begin
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = p;
            if (eligible(mr, mc)) begin
                e = 1'b1;
                f = is_last(mr, mc);
                for (int rr = 0; rr < K; rr++)
                    for (int kk = 0; kk < K; kk++)
                        d[(rr * K + kk) * N +: N] = img[mr - (K - 1) + rr][mc - (K - 1) + kk];
            end
            idx = mr * W + mc;
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end
        pix_valid = v;
        sof       = s;
        pix_in    = p;
        @(posedge clk);
        exp_en  = e;
        exp_fd  = f;
        exp_idx = idx;
        if (e) exp_dat = d;
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, 1'b0, '0);
    endtask

    task automatic clear_stats();
        win_cnt   = 0;
        fd_cnt    = 0;
        first_idx = -1;
        fd_idx    = -1;
        first_win = '0;
    endtask

    // compare DUT against the model on every cycle out of reset
    always @(negedge clk) begin
        if (!rst) begin
            chk("en_out", 64'(en_out), 64'(exp_en));
            if (exp_en) begin
                chk("data2conv", 64'(data2conv), 64'(exp_dat));
                chk("frame_done", 64'(frame_done), 64'(exp_fd));
            end else begin
                chk("frame_done_idle", 64'(frame_done), 64'd0);
            end
            if (en_out) begin
                if (win_cnt == 0) begin
                    first_win = data2conv;
                    first_idx = exp_idx;
                end
                win_cnt++;
                if (frame_done) begin
                    fd_cnt++;
                    fd_idx = exp_idx;
                end
            end
        end
    end

    task automatic plan_checks(input string tag);
        chk({tag, "_first_idx"}, 64'(first_idx), 64'd12);
        chk({tag, "_first_win"}, 64'(first_win), 64'(plan_win()));
        chk({tag, "_win_count"}, 64'(win_cnt), 64'(EXP_WINS));
        chk({tag, "_fd_count"}, 64'(fd_cnt), 64'd1);
        chk({tag, "_fd_idx"}, 64'(fd_idx), 64'(EXP_LAST));
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_data2conv", 64'(data2conv), 64'd0);
        chk("rst_en_out", 64'(en_out), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // continuous frame
        clear_stats();
        for (int p = 0; p < W * H; p++) step(1'b1, p == 0, pv(p));
        drain(3);
        plan_checks("cont");

        // gaps after pixels 7 and 13
        clear_stats();
        for (int p = 0; p < W * H; p++) begin
            step(1'b1, p == 0, pv(p));
            if (p == 7 || p == 13) drain(3);
        end
        drain(3);
        plan_checks("gap");

        // back-to-back frames; stats restart once frame one's last window is out
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < W * H; p++) begin
                step(1'b1, p == 0, pv(p));
                if (f == 1 && p == 0) clear_stats();
            end
        end
        drain(3);
        plan_checks("b2b");

        // sof at pixel 8 of a random-valued partial frame
        clear_stats();
        for (int p = 0; p < 8; p++) step(1'b1, p == 0, 4'($urandom));
        for (int p = 0; p < W * H; p++) step(1'b1, p == 0, pv(p));
        drain(3);
        plan_checks("sof_mid");

        // reset after pixel 15, restart without sof
        for (int p = 0; p < 16; p++) step(1'b1, p == 0, pv(p));
        #3 rst = 1'b1;
        pix_valid = 1'b0;
        sof       = 1'b0;
        #1;
        chk("midrst_data2conv", 64'(data2conv), 64'd0);
        chk("midrst_en_out", 64'(en_out), 64'd0);
        mr = 0;
        mc = 0;
        exp_en = 1'b0;
        exp_fd = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        clear_stats();
        for (int p = 0; p < W * H; p++) step(1'b1, 1'b0, pv(p));
        drain(3);
        plan_checks("rst_restart");

        // randomized frames with gaps, stray sof on idle cycles and an abort
        for (int f = 0; f < 5; f++) begin
            for (int p = 0; p < W * H; p++) begin
                if ($urandom_range(3) == 0) begin
                    repeat ($urandom_range(2, 1)) step(1'b0, 1'($urandom_range(1)), 4'($urandom));
                end
                step(1'b1, (p == 0 && $urandom_range(1) == 1) || (f == 2 && p == 10), 4'($urandom));
            end
        end
        drain(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
